crubits: RTL and testbench

// - TI-99/4A CRU (Communication Register Unit) bit-bank for the TIPI PEB card.
// - Decodes CRU cycles at the card's selected base and latches 4 writeable

---
 rtl/crubits_pkg.sv | 17 +
 rtl/crubits_cru_decode.sv | 35 +++
 rtl/crubits.sv | 66 ++++++
 tb/tb_crubits.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/crubits_pkg.sv
`default_nettype none
// ============================================================================
// Module   : crubits_pkg
// Brief    : Shared constants for the TIPI CRU bit-bank.
// Revision : 1.0  initial release
// ============================================================================
package crubits_pkg;

  // addr[0:3] must match this prefix to land in the >1xxx CRU space
  localparam logic [3:0] CRU_PREFIX = 4'b0001;
  // Number of latched CRU bits; the decode is built for exactly four
  localparam int         NUM_BITS   = 4;
  // Width of the bit index taken from addr[13:14]
  localparam int         CRU_IDX_W  = 2;

endpackage : crubits_pkg
`default_nettype wire

// File: rtl/crubits_cru_decode.sv
`default_nettype none
// ============================================================================
// Module   : cru_decode
// Brief    : Combinational CRU address decode. Flags a hit when the address
//            selects this card's base with a bit offset below four during a
//            CRU cycle, and extracts the bit index.
// Revision : 1.0  initial release
// ============================================================================
module cru_decode #(
  parameter logic [3:0] CRU_PREFIX = crubits_pkg::CRU_PREFIX
) (
  input  logic [0:14]                       i_addr,
  input  logic [0:3]                        i_cru_base,
  input  logic                              i_memen,
  output logic                              o_hit,
  output logic [crubits_pkg::CRU_IDX_W-1:0] o_idx
);

  logic w_prefix_ok;
  logic w_base_ok;
  logic w_offset_ok;

  // Address bus is big-endian: A0 is the MSB, so slices read left to right
  assign w_prefix_ok = (i_addr[0:3] == CRU_PREFIX);
  assign w_base_ok   = (i_addr[4:7] == i_cru_base);
  // Offsets of four or more fall outside the bank
  assign w_offset_ok = (i_addr[8:12] == 5'b00000);

  // MEMEN is active-low, so a high level marks a CRU (non-memory) cycle
  assign o_hit = w_prefix_ok && w_base_ok && w_offset_ok && i_memen;
  // A13 is the more significant index bit
  assign o_idx = i_addr[13:14];

endmodule : cru_decode
`default_nettype wire

// File: rtl/crubits.sv
`default_nettype none
// ============================================================================
// Module   : crubits
// Brief    : TI-99/4A CRU bit-bank for the TIPI PEB card. Latches four
//            writeable control bits on the CRUCLK falling edge and returns the
//            addressed bit on CRUIN. Bit 0 is the card enable.
// Revision : 1.0  initial release
// ============================================================================
module crubits #(
  parameter logic [3:0] CRU_PREFIX = crubits_pkg::CRU_PREFIX,
  parameter int         NUM_BITS   = crubits_pkg::NUM_BITS
) (
  input  logic                ti_cru_clk,
  input  logic                reset,
  input  logic [0:3]          cru_base,
  input  logic                ti_memen,
  input  logic                ti_ph3,
  input  logic [0:14]         addr,
  input  logic                ti_cru_out,
  output logic                ti_cru_in,
  output logic [0:NUM_BITS-1] bits
);

  import crubits_pkg::*;

  logic                 w_hit;
  logic [CRU_IDX_W-1:0] w_idx;
  logic [0:NUM_BITS-1]  w_we;
  logic                 r_bits [NUM_BITS];

  // PH3 is only present for pin compatibility with the original card
  logic w_ph3_unused;
  assign w_ph3_unused = ti_ph3;

  cru_decode #(
    .CRU_PREFIX (CRU_PREFIX)
  ) u_decode (
    .i_addr     (addr),
    .i_cru_base (cru_base),
    .i_memen    (ti_memen),
    .o_hit      (w_hit),
    .o_idx      (w_idx)
  );

  for (genvar gi = 0; gi < NUM_BITS; gi++) begin : g_bit
    // Only the addressed bit is enabled; the others hold their value
    assign w_we[gi] = w_hit && (w_idx == CRU_IDX_W'(gi));

    // Latch CRUOUT on the falling CRUCLK edge; reset clears and blocks writes
    always_ff @(negedge ti_cru_clk or posedge reset) begin
      if (reset) begin
        r_bits[gi] <= 1'b0;
      end else if (w_we[gi]) begin
        r_bits[gi] <= ti_cru_out;
      end
    end

    assign bits[gi] = r_bits[gi];
  end : g_bit

  // Readback is purely combinational; misses return 0, and during reset the
  // cleared flops return 0 as well
  assign ti_cru_in = w_hit ? r_bits[w_idx] : 1'b0;

endmodule : crubits
`default_nettype wire

// File: tb/tb_crubits.sv
`default_nettype none
// ============================================================================
// Module   : tb_crubits
// Brief    : Self-checking bench for the CRU bit-bank: directed scenarios
//            followed by randomized CRU cycles against a behavioural model.
// Revision : 1.0  initial release
// ============================================================================
module tb_crubits;

  logic        ti_cru_clk = 1'b1;
  logic        reset      = 1'b1;
  logic [0:3]  cru_base   = 4'b0000;
  logic        ti_memen   = 1'b0;
  logic        ti_ph3     = 1'b0;
  logic [0:14] addr       = 15'h0000;
  logic        ti_cru_out = 1'b0;
  logic        ti_cru_in;
  logic [0:3]  bits;

  int n_checks = 0;
  int n_pass   = 0;
  int mb [4];

  crubits dut (
    .ti_cru_clk (ti_cru_clk),
    .reset      (reset),
    .cru_base   (cru_base),
    .ti_memen   (ti_memen),
    .ti_ph3     (ti_ph3),
    .addr       (addr),
    .ti_cru_out (ti_cru_out),
    .ti_cru_in  (ti_cru_in),
    .bits       (bits)
  );

  always #5 ti_cru_clk = ~ti_cru_clk;
  always #7 ti_ph3     = ~ti_ph3;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference decode from the address arithmetic of the TI CRU map
  function automatic bit m_hit(input int a, input int base, input bit memen);
    return (((a >> 11) & 15) == 1) && (((a >> 7) & 15) == base) &&
           (((a >> 2) & 31) == 0) && memen;
  endfunction

  // Pack model bits with bit 0 as the leftmost (MSB) position
  function automatic logic [3:0] m_bits();
    int v = 0;
    for (int i = 0; i < 4; i++) v = v * 2 + mb[i];
    return v[3:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mb[i] = 0;
  endtask

  // One CRUCLK period: drive after the rising edge, check after the falling edge
  task automatic cycle(input int a, input int base, input bit memen, input bit d);
    bit h;
    @(posedge ti_cru_clk); #1;
    addr = a[14:0]; cru_base = base[3:0]; ti_memen = memen; ti_cru_out = d;
    @(negedge ti_cru_clk); #1;
    h = m_hit(a, base, memen);
    if (!reset && h) mb[a & 3] = int'(d);
    check("bits", bits, m_bits());
    check("cru_in", ti_cru_in, (h && !reset) ? mb[a & 3] : 0);
  endtask

  // Asynchronous reset pulse while the strobe is low
  task automatic async_reset_pulse();
    reset = 1'b1; #1;
    model_reset();
    check("arst_bits", bits, 4'b0000);
    check("arst_cru_in", ti_cru_in, 1'b0);
    #1 reset = 1'b0;
  endtask

  initial begin
    model_reset();
    // Reset held with a hitting write pending: nothing may latch
    addr = 15'h0800; ti_memen = 1'b1; ti_cru_out = 1'b1;
    @(negedge ti_cru_clk); #1;
    check("rst_bits", bits, 4'b0000);
    check("rst_cru_in", ti_cru_in, 1'b0);
    @(posedge ti_cru_clk); #1;
    ti_memen = 1'b0; reset = 1'b0;
    @(negedge ti_cru_clk); #1;
    check("rst_release", bits, 4'b0000);

    // Walk a one through all four bits
    cycle(32'h0800, 0, 1, 1); check("walk0", bits, 4'b1000);
    cycle(32'h0801, 0, 1, 1); check("walk1", bits, 4'b1100);
    cycle(32'h0802, 0, 1, 1); check("walk2", bits, 4'b1110);
    cycle(32'h0803, 0, 1, 1); check("walk3", bits, 4'b1111);

    // Clear bit 2 then read it back
    cycle(32'h0802, 0, 1, 0); check("clear", bits, 4'b1101);
    cycle(32'h0802, 0, 1, 0); check("clear_rd", ti_cru_in, 1'b0);

    // Misses: wrong base, offset >= 4, memory cycle, wrong prefix
    cycle(32'h0800, 5, 1, 0); check("miss_base", bits, 4'b1101);
    cycle(32'h0804, 0, 1, 0); check("miss_off", bits, 4'b1101);
    cycle(32'h0800, 0, 0, 0); check("miss_mem", bits, 4'b1101);
    cycle(32'h1800, 0, 1, 0); check("miss_pfx", bits, 4'b1101);

    // Moved base window
    cycle(32'h0A81, 5, 1, 0); check("base_clr", bits, 4'b1001);
    cycle(32'h0A81, 5, 1, 1); check("base_set", bits, 4'b1101);
    check("base_rd", ti_cru_in, 1'b1);

    // Async reset from all-ones with the strobe low
    cycle(32'h0802, 0, 1, 1); check("all_ones", bits, 4'b1111);
    ti_memen = 1'b0;
    async_reset_pulse();

    // Randomized CRU traffic, biased towards hits
    for (int n = 0; n < 400; n++) begin
      int pfx, bf, mid, idx, base, a;
      bit memen, d;
      base  = (n % 50 == 0) ? $urandom_range(0, 15) : 5;
      pfx   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 15) : 1;
      bf    = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 15) : base;
      mid   = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 31) : 0;
      idx   = $urandom_range(0, 3);
      memen = ($urandom_range(0, 4) != 0);
      d     = $urandom_range(0, 1);
      a     = (pfx << 11) | (bf << 7) | (mid << 2) | idx;
      cycle(a, base, memen, d);
      if ($urandom_range(0, 39) == 0) async_reset_pulse();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_crubits
`default_nettype wire
